// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic (write and read sides).
package fifo_pkg;

  // Widest pointer the helpers handle; callers zero-extend and truncate.
  localparam int unsigned PtrMaxW = 32;

  typedef logic [PtrMaxW-1:0] ptr_max_t;

  // Address width for a power-of-two depth.
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Binary to Gray; zero-extension of the input leaves the result correct.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary; upper zero bits fold away for narrower pointers.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PtrMaxW-1] = g[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full when the write Gray pointer equals the read Gray pointer with its two
  // MSBs inverted (one lap ahead). aw is the address width, pointer is aw+1.
  function automatic logic full_cmp(input ptr_max_t wgray, input ptr_max_t rgray,
                                    input int unsigned aw);
    ptr_max_t mask;
    mask = ptr_max_t'(3) << (aw - 1);
    return wgray == (rgray ^ mask);
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// N-stage reset-to-zero synchronizer for a Gray pointer crossing clock domains.
module ptr_sync #(
  parameter int unsigned WIDTH_P = 4,
  parameter int unsigned STAGES  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [WIDTH_P-1:0] i_d,
  output logic [WIDTH_P-1:0] o_q
);

  logic [WIDTH_P-1:0] r_stage [STAGES];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer, full / almost-full, fill level and sticky overflow for
// the dual-clock FIFO. Everything here runs on w_clk.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AF_THRESH   = DEPTH - 2,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned AW         = addr_w(DEPTH)
) (
  input  logic          w_clk,
  input  logic          rst_n,
  input  logic          wr_rq,
  input  logic          clr_ovf,
  input  logic [AW:0]   rptr,
  output logic          wr_en,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   wptr,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wlevel,
  output logic          overflow
);

  localparam int unsigned PtrW = AW + 1;

  // Reject unusable parameter sets at elaboration.
  if (WIDTH == 0 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2)
  begin : g_param_check
    $error("wptr_full: illegal parameter set");
  end

  logic [AW:0] r_bin;
  logic [AW:0] r_wptr;
  logic [AW:0] r_wlevel;
  logic        r_full;
  logic        r_af;
  logic        r_ovf;

  logic        w_inc;
  logic [AW:0] w_binnext;
  logic [AW:0] w_graynext;
  logic [AW:0] w_wq_rptr;
  logic [AW:0] w_rbin;
  logic [AW:0] w_level_next;
  logic        w_full_next;
  logic        w_af_next;
  logic        w_ovf_next;

  ptr_sync #(
    .WIDTH_P (PtrW),
    .STAGES  (SYNC_STAGES)
  ) u_rptr_sync (
    .i_clk   (w_clk),
    .i_rst_n (rst_n),
    .i_d     (rptr),
    .o_q     (w_wq_rptr)
  );

  // A request while full is dropped: no memory write, pointer holds.
  assign w_inc      = wr_rq & ~r_full;
  assign w_binnext  = r_bin + PtrW'(w_inc);
  assign w_graynext = PtrW'(bin2gray(ptr_max_t'(w_binnext)));
  assign w_rbin     = PtrW'(gray2bin(ptr_max_t'(w_wq_rptr)));

  // Level uses the stale synchronized read pointer, so it can only overstate.
  assign w_level_next = w_binnext - w_rbin;
  assign w_full_next  = full_cmp(ptr_max_t'(w_graynext), ptr_max_t'(w_wq_rptr), AW);
  assign w_af_next    = 32'(w_level_next) >= AF_THRESH;

  // Sticky overflow; a set in the same cycle as a clear wins.
  always_comb begin
    w_ovf_next = r_ovf;
    if (clr_ovf) begin
      w_ovf_next = 1'b0;
    end
    if (wr_rq && r_full) begin
      w_ovf_next = 1'b1;
    end
  end

  // Pointer, flag and level registers.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin    <= '0;
      r_wptr   <= '0;
      r_wlevel <= '0;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_bin    <= w_binnext;
      r_wptr   <= w_graynext;
      r_wlevel <= w_level_next;
      r_full   <= w_full_next;
      r_af     <= w_af_next;
      r_ovf    <= w_ovf_next;
    end
  end

  assign wr_en       = w_inc;
  assign waddr       = r_bin[AW-1:0];
  assign wptr        = r_wptr;
  assign full        = r_full;
  assign almost_full = r_af;
  assign wlevel      = r_wlevel;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_wptr_full.sv
// Scoreboard bench for wptr_full: the driver pushes the expected per-cycle view
// from a count-based reference model; a monitor pops and compares each cycle.
`timescale 1ns/1ps
module tb_wptr_full;

  localparam int unsigned Depth = 8;
  localparam int unsigned Sync  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_rq = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] rptr = '0;
  logic       wr_en;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wlevel;
  logic       overflow;

  wptr_full dut (
    .w_clk       (clk),
    .rst_n       (rst_n),
    .wr_rq       (wr_rq),
    .clr_ovf     (clr_ovf),
    .rptr        (rptr),
    .wr_en       (wr_en),
    .waddr       (waddr),
    .wptr        (wptr),
    .full        (full),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       full;
    logic       af;
    logic [3:0] wlevel;
    logic       ovf;
  } exp_t;

  exp_t q_exp[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: total accepted writes, history of presented read counts.
  int unsigned m_wcnt = 0;
  int unsigned m_level = 0;
  logic        m_full = 1'b0;
  logic        m_af = 1'b0;
  logic        m_ovf = 1'b0;
  int unsigned m_rhist[$];

  int unsigned fill_tbl[8] = '{1, 3, 2, 6, 7, 5, 4, 12};

  function automatic logic [3:0] gray4(input int unsigned n);
    logic [3:0] b;
    b = 4'(n % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_wcnt  = 0;
    m_level = 0;
    m_full  = 1'b0;
    m_af    = 1'b0;
    m_ovf   = 1'b0;
    m_rhist.delete();
    for (int i = 0; i < Sync; i++) m_rhist.push_back(0);
  endtask

  // One write-clock cycle: drive, push the expectation, then advance the model.
  task automatic cycle(input bit wr, input bit clr, input int unsigned rcnt);
    exp_t e;
    int unsigned rused;
    bit accept;
    @(negedge clk);
    wr_rq   = wr;
    clr_ovf = clr;
    rptr    = gray4(rcnt);
    e.wr_en  = wr & ~m_full;
    e.waddr  = 3'(m_wcnt % Depth);
    e.wptr   = gray4(m_wcnt);
    e.full   = m_full;
    e.af     = m_af;
    e.wlevel = 4'(m_level);
    e.ovf    = m_ovf;
    q_exp.push_back(e);
    @(posedge clk);
    accept = wr && !m_full;
    m_rhist.push_back(rcnt);
    rused   = m_rhist.pop_front();
    m_ovf   = (wr && m_full) || (m_ovf && !clr);
    m_wcnt  = m_wcnt + (accept ? 1 : 0);
    m_level = m_wcnt - rused;
    m_full  = (m_level == Depth);
    m_af    = (m_level >= Depth - 2);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    wr_rq = 1'b1;
    clr_ovf = 1'b0;
    rptr = '0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 1);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wptr", 32'(wptr), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_wlevel", 32'(wlevel), 0);
    chk("rst_ovf", 32'(overflow), 0);
    wr_rq = 1'b0;
    rst_n = 1'b1;
    model_clear();
  endtask

  // Monitor: compare the DUT view against the oldest pending expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      chk("wr_en", 32'(wr_en), 32'(e.wr_en));
      chk("waddr", 32'(waddr), 32'(e.waddr));
      chk("wptr", 32'(wptr), 32'(e.wptr));
      chk("full", 32'(full), 32'(e.full));
      chk("almost_full", 32'(almost_full), 32'(e.af));
      chk("wlevel", 32'(wlevel), 32'(e.wlevel));
      chk("overflow", 32'(overflow), 32'(e.ovf));
    end
  end

  initial begin : driver
    int unsigned rcnt;
    int unsigned step;
    // Power-on reset with a pending request: only wr_en follows wr_rq.
    #1;
    rst_n = 1'b0;
    wr_rq = 1'b1;
    #2;
    chk("por_wr_en", 32'(wr_en), 1);
    chk("por_wptr", 32'(wptr), 0);
    chk("por_full", 32'(full), 0);
    chk("por_wlevel", 32'(wlevel), 0);
    chk("por_ovf", 32'(overflow), 0);
    wr_rq = 1'b0;
    #1;
    rst_n = 1'b1;
    model_clear();

    // Fill with the reader idle; wptr must follow the Gray sequence.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 0);
      #1;
      chk("fill_wptr", 32'(wptr), fill_tbl[i]);
    end

    // Overflow while full, hold, set-beats-clear, then clear.
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 0);
    cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 0);

    // Two reads become visible after the synchronizer delay.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2);
    cycle(1'b0, 1'b0, 2);

    // Reset while full with overflow set, then resume filling from zero.
    async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);

    // Wrap: reader trails the writer by two cycles.
    async_reset();
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, (k >= 2) ? k - 2 : 0);
    cycle(1'b0, 1'b0, 18);

    // Randomized traffic with a reader that never passes the writer.
    async_reset();
    rcnt = 0;
    for (int k = 0; k < 400; k++) begin
      if (($urandom % 2) == 1 && rcnt < m_wcnt) begin
        step = $urandom_range(1, 3);
        rcnt = rcnt + ((m_wcnt - rcnt < step) ? m_wcnt - rcnt : step);
      end
      cycle(($urandom % 4) != 0, ($urandom % 8) == 0, rcnt);
    end

    @(negedge clk);
    #3;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and full-flag generator for the dual-clock FIFO. It lives entirely in the write clock domain and is the counterpart of the read-side empty logic. It accepts write requests and produces the memory write address and write enable, plus a Gray-coded write pointer for the read domain. It synchronizes the read domain's Gray pointer locally and derives `full`, `almost_full`, a fill level and a sticky overflow flag.

## Interface
Parameters:
- `WIDTH`, 4: FIFO data width; kept for uniform instantiation, no logic depends on it.
- `DEPTH`, 8: FIFO entries; power of two, at least 4. `AW = $clog2(DEPTH)`.
- `AF_THRESH`, `DEPTH-2`: `almost_full` asserts when the fill level is at or above this value.
- `SYNC_STAGES`, 2: number of flops in the read-pointer synchronizer; at least 2.

Ports:
- `w_clk`, in, 1: write clock. The block has one clock; reset is asynchronous and active-low.
- `rst_n`, in, 1: asynchronous active-low reset.
- `wr_rq`, in, 1: write request.
- `clr_ovf`, in, 1: clears `overflow`.
- `rptr`, in, AW+1: Gray read pointer from the read domain; asynchronous to `w_clk`.
- `wr_en`, out, 1: memory write enable; `wr_rq & ~full`, combinational.
- `waddr`, out, AW: memory write address.
- `wptr`, out, AW+1: Gray write pointer, registered, sent to the read domain.
- `full`, out, 1: FIFO full, registered.
- `almost_full`, out, 1: level is at or above `AF_THRESH`, registered.
- `wlevel`, out, AW+1: conservative fill level, registered.
- `overflow`, out, 1: sticky flag, set when a write is requested while full.

## Operation
- Internal binary pointer `bin` is AW+1 bits. `binnext = bin + (wr_rq & ~full)`, with modulo 2^(AW+1) wrap.
- `waddr = bin[AW-1:0]`. `wptr` registers `graynext = binnext ^ (binnext >> 1)`.
- Synchronizer: `rptr` passes through `SYNC_STAGES` flops to give `wq_rptr`.
- `full` registers the comparison `graynext == {~wq_rptr[AW:AW-1], wq_rptr[AW-2:0]}`.
- `rbin = gray2bin(wq_rptr)`. `wlevel` registers `binnext - rbin` (AW+1 bits, modulo).
- `almost_full` registers `(binnext - rbin) >= AF_THRESH`.
- `overflow` update rules:
  - Set on any cycle where `wr_rq & full`.
  - Cleared by `clr_ovf`.
  - When set and clear occur in the same cycle, set wins.
- A write while full is dropped: `wr_en` is 0 and `bin` is unchanged.
- Flags are pessimistic. Reads become visible only after the synchronizer delay, so `full` and `wlevel` may overstate occupancy but never understate it.
- Reset value of every output and register is 0: `bin`, `wptr`, `full`, `almost_full`, `wlevel`, `overflow` and all synchronizer flops. `waddr` is therefore 0 and `wr_en` equals `wr_rq`.
- Asserting `rst_n` mid-operation clears everything immediately and asynchronously. No partial write survives; the read side must be reset in the same event.

## Timing
- Write accepted at edge N (`wr_rq=1`, `full=0`):
  - Memory writes `waddr` at edge N.
  - `waddr`, `wptr` and `wlevel` reflect the new pointer after edge N.
  - `full` and `almost_full` are updated at the same edge N.
- The last free slot written at edge N gives `full=1` after N. A request at N+1 is dropped and `overflow=1` after N+1.
- A change on `rptr` before edge K:
  - The synchronizer holds it after edge K+SYNC_STAGES-1.
  - `full`, `wlevel` and `almost_full` reflect it after edge K+SYNC_STAGES.
  - With the default setting, that is 3 edges.
- `wptr` changes at most one bit per edge, so it is safe to cross domains.
- Pointer wrap: `bin` rolls from 2^(AW+1)-1 to 0 and `waddr` from DEPTH-1 to 0, with no bubble.

## Structure
- Package `fifo_pkg` holds:
  - the `addr_w(DEPTH)` function;
  - the `bin2gray` and `gray2bin` functions, parameterized by width;
  - the MSB-inversion "full compare" helper.
  - The read-side empty logic shares all of these.
- One sub-module, `ptr_sync`, provides the N-stage reset-to-0 synchronizer (`WIDTH_P`, `STAGES`). It is reusable for the read-side `wptr` crossing.

## Test plan
- Reset: `rst_n=0` with `wr_rq=1` → all outputs 0 except `wr_en=1`; after release `waddr=0` and `wptr=0`.
- Fill with `rptr=0`, DEPTH=8, 8 writes:
  - `waddr` runs 0..7;
  - `wptr` runs 1,3,2,6,7,5,4,12;
  - `almost_full=1` after the 6th write;
  - `full=1` and `wlevel=8` after the 8th write.
- Overflow: a 9th `wr_rq` while full → `wr_en=0`, `waddr` stays 0, `overflow=1`.
  - `overflow` holds until `clr_ovf`.
  - With `clr_ovf` and `wr_rq` both asserted while full, `overflow` stays 1.
- Drain visibility: with the FIFO full, set `rptr=3` (binary 2) → `full=0` and `wlevel=6` after the 3rd edge. Two further writes set `full=1` again, and the 3rd is dropped.
- Wrap: 20 writes with `rptr` following `wptr` two edges late →
  - `full` never asserts;
  - `waddr` wraps 7→0 twice;
  - `wptr` equals the Gray code of the write count mod 16.
- Reset mid-operation: `rst_n` pulsed low between edges while `full=1` and `overflow=1` → all outputs 0 before the next edge, and normal filling resumes from `waddr=0`.
